// File: rtl/vending_payment_ctrl.sv
// Payment/dispense controller: collects coins against a latched price, pulses
// dispense, then pays change or refunds as a train of 5-unit coin pulses.
module vending_payment_ctrl #(
  parameter int COIN_A_VALUE   = 5,
  parameter int COIN_B_VALUE   = 10,
  parameter int COIN_C_VALUE   = 20,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] selected_price,
  input  logic       coin_valid,
  input  logic [1:0] coin_code,
  input  logic       cancel,
  output logic [5:0] credit,
  output logic       dispense,
  output logic       change_coin,
  output logic       refund,
  output logic       coin_reject,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

  localparam logic [5:0] VAL_A   = 6'(COIN_A_VALUE);
  localparam logic [5:0] VAL_B   = 6'(COIN_B_VALUE);
  localparam logic [5:0] VAL_C   = 6'(COIN_C_VALUE);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES);

  state_t     state, state_n;
  logic [5:0] credit_q, credit_n;
  logic [4:0] price_q, price_n;
  logic [7:0] cnt_q, cnt_n;
  logic       refund_q, refund_n;
  logic       rej_q, rej_n;

  logic [5:0] cval, sum, price_ext;
  logic [7:0] cnt_inc;

  always_comb begin
    case (coin_code)
      2'b01:   cval = VAL_A;
      2'b10:   cval = VAL_B;
      2'b11:   cval = VAL_C;
      default: cval = 6'd0;
    endcase
  end

  assign price_ext = {1'b0, price_q};
  assign sum       = credit_q + cval;
  assign cnt_inc   = cnt_q + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      credit_q <= 6'd0;
      price_q  <= 5'd0;
      cnt_q    <= 8'd0;
      refund_q <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      state    <= state_n;
      credit_q <= credit_n;
      price_q  <= price_n;
      cnt_q    <= cnt_n;
      refund_q <= refund_n;
      rej_q    <= rej_n;
    end
  end

  always_comb begin
    state_n  = state;
    credit_n = credit_q;
    price_n  = price_q;
    cnt_n    = cnt_q;
    refund_n = refund_q;
    rej_n    = 1'b0;
    case (state)
      IDLE: begin
        credit_n = 6'd0;
        cnt_n    = 8'd0;
        if (coin_valid) begin
          if (selected_price == 5'd0 || coin_code == 2'b00) begin
            rej_n = 1'b1;
          end else begin
            price_n  = selected_price;
            credit_n = cval;
            refund_n = 1'b0;
            state_n  = (cval >= {1'b0, selected_price}) ? DISPENSE : COLLECT;
          end
        end
      end
      COLLECT: begin
        // cancel takes priority; a coin arriving with it is bounced
        if (cancel) begin
          rej_n    = coin_valid;
          refund_n = 1'b1;
          state_n  = CHANGE;
        end else if (coin_valid && coin_code != 2'b00) begin
          credit_n = sum;
          cnt_n    = 8'd0;
          if (sum >= price_ext) state_n = DISPENSE;
        end else begin
          rej_n = coin_valid;
          cnt_n = cnt_inc;
          if (cnt_inc == TO_LAST) begin
            refund_n = 1'b1;
            state_n  = CHANGE;
          end
        end
      end
      DISPENSE: begin
        rej_n    = coin_valid;
        refund_n = 1'b0;
        cnt_n    = 8'd0;
        credit_n = credit_q - price_ext;
        state_n  = (credit_q != price_ext) ? CHANGE : IDLE;
      end
      CHANGE: begin
        rej_n = coin_valid;
        // last coin (or a sub-coin residue) finishes the train
        if (credit_q <= 6'd5) begin
          credit_n = 6'd0;
          state_n  = IDLE;
        end else begin
          credit_n = credit_q - 6'd5;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    credit      = credit_q;
    coin_reject = rej_q;
    dispense    = (state == DISPENSE);
    change_coin = (state == CHANGE) && (credit_q >= 6'd5);
    refund      = (state == CHANGE) && refund_q;
    busy        = (state != IDLE);
  end

endmodule
